count_sequencer: RTL
====================

# count_sequencer

Phase sequencer for the count/decode datapath. It runs one start-triggered cycle through four phases in order: READY, RUN, BRAKE, STOP, then back to READY. RUN and BRAKE last a programmable number of cycles; STOP lasts a fixed number. An internal phase counter drives `count`, and the phase outputs are one-hot. The block sits beside the existing free-running counter/decoder pair and replaces its fixed thresholds with commanded, abortable sequencing.

## Interface
Parameters:
- `WIDTH`, 8, width of `count`, `run_len` and `brake_len`.
- `STOP_HOLD`, 4, cycles spent in STOP. Must be ≥1 and < 2^WIDTH.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  sequence request. Sampled only in READY.
- `abort`  input  1  early termination request. Acted on only in RUN or BRAKE.
- `run_len`  input  WIDTH  RUN duration in cycles. Latched on accepted `start`.
- `brake_len`  input  WIDTH  BRAKE duration in cycles. Latched on accepted `start`.
- `count`  output  WIDTH  cycles elapsed in the current phase, starting at 0.
- `ready`, `run`, `brake`, `stop`  output  1 each  one-hot phase indicators.
- `busy`  output  1  high in every phase except READY.
- `done`  output  1  one-cycle pulse on the final STOP cycle.

## Operation
- States: READY, RUN, BRAKE, STOP. `state` and `count` are registered; all outputs decode from these registers with no combinational input-to-output path.
- Each phase change clears `count` to 0. Within a phase, `count` increments by 1 per cycle.
- READY:
  - `count` = 0.
  - `start` = 1 latches `run_len` and `brake_len` into `run_q` and `brake_q`.
  - Next state is RUN, or BRAKE if `run_q` = 0, or STOP if both are 0.
- RUN:
  - When `count` = `run_q` − 1, next state is BRAKE, or STOP if `brake_q` = 0.
- BRAKE:
  - When `count` = `brake_q` − 1, next state is STOP.
- STOP:
  - When `count` = `STOP_HOLD` − 1, `done` = 1 and next state is READY.
- `abort` = 1:
  - In RUN: next state is BRAKE (or STOP if `brake_q` = 0).
  - In BRAKE: next state is STOP.
  - In READY or STOP: ignored.
- `start` outside READY is ignored; there is no queuing.
- `start` and `abort` together in READY: `start` is accepted and `abort` is ignored.
- Lengths are unsigned. Length 2^WIDTH − 1 gives the maximum phase duration. `count` never wraps, because every phase exits before reaching its terminal value.
- Changing `run_len` or `brake_len` mid-sequence has no effect until the next accepted `start`.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - Next cycle: state READY, `count` = 0, `ready` = 1.
  - `run`, `brake`, `stop`, `busy` and `done` are 0.
  - `run_q` and `brake_q` are 0.
  - Reset mid-sequence aborts immediately, with no STOP phase and no `done`.
- Latency:
  - `start` accepted at edge N: the new phase is visible from cycle N+1 with `count` = 0.
  - `abort` at edge N: the next phase is visible at N+1.
- RUN occupies exactly `run_q` cycles, BRAKE exactly `brake_q` cycles, STOP exactly `STOP_HOLD` cycles.
- Minimum `start` spacing is 1 + `run_q` + `brake_q` + `STOP_HOLD` cycles. `start` may be held high: it re-triggers on the first READY cycle, so sequences run back to back with a single READY cycle between them.

## Configuration
- `SEQ_PAUSE_EN` defined:
  - Adds input port `pause` (1 bit).
  - `pause` = 1 in RUN or BRAKE freezes both `state` and `count`.
  - `abort` overrides `pause`.
  - `pause` has no effect in READY or STOP.
  - `busy` stays high while paused.
- `SEQ_PAUSE_EN` undefined: the `pause` port is absent and behaviour is as specified above.

## Structure
- Shared package `seq_pkg`:
  - Phase enum `seq_state_t` {READY, RUN, BRAKE, STOP}, 2-bit encoding.
  - Default constants for `WIDTH` and `STOP_HOLD`.
- One sub-module, `phase_timer`:
  - Contains the WIDTH-bit counter with clear, enable and a terminal-compare input.
  - Outputs `count` and a `last` flag.
- The FSM, length latches and output decode live in `count_sequencer`.

## Test plan
- Reset then idle: hold `reset` = 0 for 2 cycles, then release. Required: `ready` = 1, `count` = 0, `busy` = 0 for 10 cycles with `start` low.
- Nominal sequence: `run_len` = 5, `brake_len` = 3, `start` pulse.
  - RUN: `count` 0..4, then BRAKE: `count` 0..2, then STOP: `count` 0..3.
  - `done` pulses in the cycle STOP has `count` = 3; READY resumes on the next cycle.
  - Total `busy` time is 12 cycles.
- Zero lengths: `run_len` = 0, `brake_len` = 0. Required: STOP on the cycle after `start`, 4 STOP cycles, one `done` pulse.
- Abort: `run_len` = 200, `brake_len` = 10, `abort` pulse at RUN `count` = 7. Required: BRAKE on the next cycle with `count` = 0; a second `abort` at BRAKE `count` = 2 moves to STOP.
- Reset mid-sequence: `reset` = 0 during BRAKE. Required: READY next cycle, no `done`, all phase outputs except `ready` are 0.
- `SEQ_PAUSE_EN` build: `pause` held 6 cycles at RUN `count` = 2.
  - `count` stays at 2 for 6 cycles, then RUN completes normally.
  - `pause` together with `abort` in RUN moves to BRAKE.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared types and defaults for the count_sequencer phase sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    STOP  = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_STOP_HOLD = 4;

endpackage

// File: rtl/count_sequencer_if.sv
// Command/status bundle for count_sequencer. Optional pause input under SEQ_PAUSE_EN.
interface count_sequencer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  // Level-sampled control: start is taken only on a READY cycle and abort
  // only in RUN/BRAKE. There is no valid/ready handshake and no queuing.
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] run_len;
  logic [WIDTH-1:0] brake_len;
`ifdef SEQ_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] count;
  logic             ready;
  logic             run;
  logic             brake;
  logic             stop;
  logic             busy;
  logic             done;
  seq_state_t       state_dbg;

  modport master (
    output start, abort, run_len, brake_len,
`ifdef SEQ_PAUSE_EN
    output pause,
`endif
    input  count, ready, run, brake, stop, busy, done, state_dbg
  );

  modport slave (
    input  start, abort, run_len, brake_len,
`ifdef SEQ_PAUSE_EN
    input  pause,
`endif
    output count, ready, run, brake, stop, busy, done, state_dbg
  );

endinterface

// File: rtl/count_sequencer_phase_timer.sv
// Per-phase cycle counter with clear, enable and a terminal-compare flag.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign last = (count == term);

endmodule

// File: rtl/count_sequencer.sv
// READY -> RUN -> BRAKE -> STOP sequencer with latched lengths and abort.
// Build with SEQ_PAUSE_EN defined to add the pause input.
module count_sequencer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STOP_HOLD = DEF_STOP_HOLD
) (
  input logic              clk,
  input logic              reset,
  count_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] STOP_TERM = WIDTH'(STOP_HOLD - 1);

  seq_state_t       state, state_next;
  logic [WIDTH-1:0] run_q, brake_q, term, count;
  logic             last, clr, en, freeze;

`ifdef SEQ_PAUSE_EN
  // abort still wins over pause, so freezing is only for a non-aborting cycle
  assign freeze = bus.pause && !bus.abort && (state == RUN || state == BRAKE);
`else
  assign freeze = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q   <= '0;
      brake_q <= '0;
    end else if (state == READY && bus.start) begin
      run_q   <= bus.run_len;
      brake_q <= bus.brake_len;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      READY: if (bus.start) begin
        if (bus.run_len != '0)        state_next = RUN;
        else if (bus.brake_len != '0) state_next = BRAKE;
        else                          state_next = STOP;
      end
      RUN:   if (bus.abort || (last && !freeze))
               state_next = (brake_q != '0) ? BRAKE : STOP;
      BRAKE: if (bus.abort || (last && !freeze)) state_next = STOP;
      STOP:  if (last) state_next = READY;
      default: state_next = READY;
    endcase
  end

  // Terminal count per phase; RUN/BRAKE are only entered with a nonzero length.
  always_comb begin
    term = '0;
    case (state)
      RUN:     term = run_q - WIDTH'(1);
      BRAKE:   term = brake_q - WIDTH'(1);
      STOP:    term = STOP_TERM;
      default: term = '0;
    endcase
  end

  assign clr = (state_next != state);
  assign en  = (state != READY) && !freeze;

  phase_timer #(.WIDTH(WIDTH)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .term  (term),
    .count (count),
    .last  (last)
  );

  always_comb begin
    bus.ready     = 1'b0;
    bus.run       = 1'b0;
    bus.brake     = 1'b0;
    bus.stop      = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.count     = count;
    bus.state_dbg = state;
    case (state)
      READY:   bus.ready = 1'b1;
      RUN:     bus.run   = 1'b1;
      BRAKE:   bus.brake = 1'b1;
      STOP:    bus.stop  = 1'b1;
      default: bus.ready = 1'b0;
    endcase
    bus.busy = (state != READY);
    bus.done = (state == STOP) && last;
  end

endmodule
